// File: rtl/fft_pkg.sv
// Shared FFT datapath constants and the round/saturate helpers
// used by the butterfly output stage.
package fft_pkg;

  localparam int BUTTERFLY_LATENCY = 3;

  localparam int OUT_SAT_A_RE = 3;
  localparam int OUT_SAT_A_IM = 2;
  localparam int OUT_SAT_B_RE = 1;
  localparam int OUT_SAT_B_IM = 0;

  localparam int RS_W = 64;

  typedef logic signed [RS_W-1:0] wide_t;

  typedef struct packed {
    logic signed [RS_W-1:0] val;
    logic                   sat;
  } rs_t;

  // Round half toward +inf, then arithmetic shift right by sh.
  function automatic wide_t round_shift(
    input wide_t x,
    input int    sh
  );
    wide_t half;
    wide_t sum;
    half = wide_t'(1) <<< (sh - 1);
    sum  = x + half;
    return sum >>> sh;
  endfunction

  function automatic rs_t sat_clip(
    input wide_t x,
    input int    w
  );
    wide_t hi;
    wide_t lo;
    rs_t   r;
    hi    = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo    = -(wide_t'(1) <<< (w - 1));
    r.sat = (x > hi) || (x < lo);
    r.val = (x > hi) ? hi : ((x < lo) ? lo : x);
    return r;
  endfunction

  function automatic rs_t round_sat(
    input wide_t x,
    input logic  scale,
    input int    w
  );
    int sh;
    sh = w - 1 + (scale ? 1 : 0);
    return sat_clip(round_shift(x, sh), w);
  endfunction

endpackage

// File: rtl/cmul_pipe.sv
// Registered four-product complex multiply front end (1 cycle),
// holding its contents whenever en is low.
module cmul_pipe
  import fft_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic signed [W-1:0]   b_re,
  input  logic signed [W-1:0]   b_im,
  input  logic signed [W-1:0]   w_re,
  input  logic signed [W-1:0]   w_im,
  output logic                  out_valid,
  output logic signed [2*W-1:0] rr,
  output logic signed [2*W-1:0] ii,
  output logic signed [2*W-1:0] ri,
  output logic signed [2*W-1:0] ir
);

  localparam int PW = 2 * W;

  logic                 v_d, v_q;
  logic signed [PW-1:0] rr_d, rr_q;
  logic signed [PW-1:0] ii_d, ii_q;
  logic signed [PW-1:0] ri_d, ri_q;
  logic signed [PW-1:0] ir_d, ir_q;

  always_comb begin
    v_d  = v_q;
    rr_d = rr_q;
    ii_d = ii_q;
    ri_d = ri_q;
    ir_d = ir_q;
    if (en) begin
      v_d  = in_valid;
      rr_d = PW'(b_re) * PW'(w_re);
      ii_d = PW'(b_im) * PW'(w_im);
      ri_d = PW'(b_re) * PW'(w_im);
      ir_d = PW'(b_im) * PW'(w_re);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q  <= 1'b0;
      rr_q <= '0;
      ii_q <= '0;
      ri_q <= '0;
      ir_q <= '0;
    end else begin
      v_q  <= v_d;
      rr_q <= rr_d;
      ii_q <= ii_d;
      ri_q <= ri_d;
      ir_q <= ir_d;
    end
  end

  assign out_valid = v_q;
  assign rr        = rr_q;
  assign ii        = ii_q;
  assign ri        = ri_q;
  assign ir        = ir_q;

endmodule

// File: rtl/butterfly_pipe.sv
// Three-stage radix-2 DIT butterfly: A' = A + B*W, B' = A - B*W,
// with optional /2 scaling, round-half-up, saturation and stall.
module butterfly_pipe
  import fft_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int SAT_CNT_W = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [BIT_WIDTH-1:0] a_re,
  input  logic signed [BIT_WIDTH-1:0] a_im,
  input  logic signed [BIT_WIDTH-1:0] b_re,
  input  logic signed [BIT_WIDTH-1:0] b_im,
  input  logic signed [BIT_WIDTH-1:0] w_re,
  input  logic signed [BIT_WIDTH-1:0] w_im,
  input  logic                        in_scale,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [BIT_WIDTH-1:0] out_a_re,
  output logic signed [BIT_WIDTH-1:0] out_a_im,
  output logic signed [BIT_WIDTH-1:0] out_b_re,
  output logic signed [BIT_WIDTH-1:0] out_b_im,
  output logic [3:0]                  out_sat,
  input  logic                        clear_sat,
  output logic [SAT_CNT_W-1:0]        sat_count
);

  localparam int W  = BIT_WIDTH;
  localparam int PW = 2 * W;
  localparam int SW = 2 * W + 2;
  localparam logic [SAT_CNT_W-1:0] CNT_MAX = '1;

  logic stall, en, accept, xfer;

  // S1: products live in cmul_pipe; A and scale ride alongside.
  logic                 v1;
  logic signed [PW-1:0] rr, ii, ri, ir;
  logic signed [W-1:0]  a1_re_d, a1_re_q, a1_im_d, a1_im_q;
  logic                 sc1_d, sc1_q;

  // S2: full-precision sums, 2W-2 fractional bits.
  logic signed [PW:0]   bw_re, bw_im;
  logic signed [SW-1:0] ax_re, ax_im;
  logic signed [SW-1:0] s_ar_d, s_ar_q, s_ai_d, s_ai_q;
  logic signed [SW-1:0] s_br_d, s_br_q, s_bi_d, s_bi_q;
  logic                 sc2_d, sc2_q, v2_d, v2_q;

  // S3: rounded, saturated outputs.
  rs_t                 rs_ar, rs_ai, rs_br, rs_bi;
  logic                unused_rs_hi;
  logic signed [W-1:0] o_ar_d, o_ar_q, o_ai_d, o_ai_q;
  logic signed [W-1:0] o_br_d, o_br_q, o_bi_d, o_bi_q;
  logic [3:0]          sat_d, sat_q;
  logic                ov_d, ov_q;
  logic [SAT_CNT_W-1:0] cnt_d, cnt_q;

  assign stall    = ov_q & ~out_ready;
  assign en       = ~stall;
  assign in_ready = en;
  assign accept   = in_valid & en;
  assign xfer     = ov_q & out_ready;

  cmul_pipe #(.W(W)) u_cmul (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (accept),
    .b_re      (b_re),
    .b_im      (b_im),
    .w_re      (w_re),
    .w_im      (w_im),
    .out_valid (v1),
    .rr        (rr),
    .ii        (ii),
    .ri        (ri),
    .ir        (ir)
  );

  always_comb begin
    a1_re_d = a1_re_q;
    a1_im_d = a1_im_q;
    sc1_d   = sc1_q;
    if (accept) begin
      a1_re_d = a_re;
      a1_im_d = a_im;
      sc1_d   = in_scale;
    end
  end

  always_comb begin
    bw_re  = (PW+1)'(rr) - (PW+1)'(ii);
    bw_im  = (PW+1)'(ri) + (PW+1)'(ir);
    ax_re  = SW'(a1_re_q) <<< (W - 1);
    ax_im  = SW'(a1_im_q) <<< (W - 1);
    s_ar_d = s_ar_q;
    s_ai_d = s_ai_q;
    s_br_d = s_br_q;
    s_bi_d = s_bi_q;
    sc2_d  = sc2_q;
    v2_d   = v2_q;
    if (en) begin
      v2_d = v1;
      if (v1) begin
        s_ar_d = ax_re + SW'(bw_re);
        s_ai_d = ax_im + SW'(bw_im);
        s_br_d = ax_re - SW'(bw_re);
        s_bi_d = ax_im - SW'(bw_im);
        sc2_d  = sc1_q;
      end
    end
  end

  always_comb begin
    rs_ar  = round_sat(wide_t'(s_ar_q), sc2_q, W);
    rs_ai  = round_sat(wide_t'(s_ai_q), sc2_q, W);
    rs_br  = round_sat(wide_t'(s_br_q), sc2_q, W);
    rs_bi  = round_sat(wide_t'(s_bi_q), sc2_q, W);
    o_ar_d = o_ar_q;
    o_ai_d = o_ai_q;
    o_br_d = o_br_q;
    o_bi_d = o_bi_q;
    sat_d  = sat_q;
    ov_d   = ov_q;
    if (en) begin
      ov_d = v2_q;
      if (v2_q) begin
        o_ar_d = rs_ar.val[W-1:0];
        o_ai_d = rs_ai.val[W-1:0];
        o_br_d = rs_br.val[W-1:0];
        o_bi_d = rs_bi.val[W-1:0];
        sat_d[OUT_SAT_A_RE] = rs_ar.sat;
        sat_d[OUT_SAT_A_IM] = rs_ai.sat;
        sat_d[OUT_SAT_B_RE] = rs_br.sat;
        sat_d[OUT_SAT_B_IM] = rs_bi.sat;
      end
    end
  end

  assign unused_rs_hi = ^{rs_ar.val[RS_W-1:W], rs_ai.val[RS_W-1:W],
                          rs_br.val[RS_W-1:W], rs_bi.val[RS_W-1:W]};

  always_comb begin
    cnt_d = cnt_q;
    if (clear_sat) begin
      cnt_d = '0;
    end else if (xfer && (|sat_q) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a1_re_q <= '0;
      a1_im_q <= '0;
      sc1_q   <= 1'b0;
      s_ar_q  <= '0;
      s_ai_q  <= '0;
      s_br_q  <= '0;
      s_bi_q  <= '0;
      sc2_q   <= 1'b0;
      v2_q    <= 1'b0;
      o_ar_q  <= '0;
      o_ai_q  <= '0;
      o_br_q  <= '0;
      o_bi_q  <= '0;
      sat_q   <= '0;
      ov_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a1_re_q <= a1_re_d;
      a1_im_q <= a1_im_d;
      sc1_q   <= sc1_d;
      s_ar_q  <= s_ar_d;
      s_ai_q  <= s_ai_d;
      s_br_q  <= s_br_d;
      s_bi_q  <= s_bi_d;
      sc2_q   <= sc2_d;
      v2_q    <= v2_d;
      o_ar_q  <= o_ar_d;
      o_ai_q  <= o_ai_d;
      o_br_q  <= o_br_d;
      o_bi_q  <= o_bi_d;
      sat_q   <= sat_d;
      ov_q    <= ov_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = ov_q;
  assign out_a_re  = o_ar_q;
  assign out_a_im  = o_ai_q;
  assign out_b_re  = o_br_q;
  assign out_b_im  = o_bi_q;
  assign out_sat   = sat_q;
  assign sat_count = cnt_q;

endmodule

// File: tb/tb_butterfly_pipe.sv
// Directed + scoreboard bench for butterfly_pipe (BIT_WIDTH=8).
// Inputs change at posedge+2, outputs are sampled on negedge.
module tb_butterfly_pipe;

  localparam int BW = 8;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic in_scale = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic clear_sat = 1'b0;
  logic signed [BW-1:0] a_re = '0, a_im = '0;
  logic signed [BW-1:0] b_re = '0, b_im = '0;
  logic signed [BW-1:0] w_re = '0, w_im = '0;
  logic signed [BW-1:0] out_a_re, out_a_im, out_b_re, out_b_im;
  logic [3:0]           out_sat;
  logic [CW-1:0]        sat_count;

  typedef struct packed {
    logic [7:0] ar;
    logic [7:0] ai;
    logic [7:0] br;
    logic [7:0] bi;
    logic [3:0] sat;
  } exp_t;

  typedef struct {
    int ar, ai, br, bi, wr, wi;
    bit sc;
  } op_t;

  exp_t q[$];
  exp_t mon_exp, mon_obs;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_out = 0;

  butterfly_pipe #(.BIT_WIDTH(BW), .SAT_CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_re      (a_re),
    .a_im      (a_im),
    .b_re      (b_re),
    .b_im      (b_im),
    .w_re      (w_re),
    .w_im      (w_im),
    .in_scale  (in_scale),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a_re  (out_a_re),
    .out_a_im  (out_a_im),
    .out_b_re  (out_b_re),
    .out_b_im  (out_b_im),
    .out_sat   (out_sat),
    .clear_sat (clear_sat),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] want);
    n_chk++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, want);
  endtask

  // Reference: Q1.7 inputs, products carry 14 fractional bits.
  function automatic void rs(input int x, input bit sc,
                             output logic [7:0] v, output logic s);
    int sh;
    int r;
    sh = 7 + (sc ? 1 : 0);
    r  = (x + (1 <<< (sh - 1))) >>> sh;
    s  = (r > 127) || (r < -128);
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    v = 8'(r);
  endfunction

  function automatic exp_t model(input op_t o);
    exp_t e;
    int   bwr;
    int   bwi;
    logic s3, s2, s1, s0;
    bwr = o.br * o.wr - o.bi * o.wi;
    bwi = o.br * o.wi + o.bi * o.wr;
    rs(o.ar * 128 + bwr, o.sc, e.ar, s3);
    rs(o.ai * 128 + bwi, o.sc, e.ai, s2);
    rs(o.ar * 128 - bwr, o.sc, e.br, s1);
    rs(o.ai * 128 - bwi, o.sc, e.bi, s0);
    e.sat = {s3, s2, s1, s0};
    return e;
  endfunction

  function automatic op_t mk(input int ar, ai, br, bi, wr, wi,
                             input bit sc);
    op_t o;
    o.ar = ar; o.ai = ai; o.br = br; o.bi = bi;
    o.wr = wr; o.wi = wi; o.sc = sc;
    return o;
  endfunction

  task automatic drive(input op_t o);
    a_re = 8'(o.ar); a_im = 8'(o.ai);
    b_re = 8'(o.br); b_im = 8'(o.bi);
    w_re = 8'(o.wr); w_im = 8'(o.wi);
    in_scale = o.sc;
  endtask

  task automatic issue(input op_t o);
    int n;
    n = 0;
    @(posedge clk); #2;
    drive(o);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("issue_ready", in_ready, 1);
    if (in_ready) q.push_back(model(o));
  endtask

  task automatic idle();
    @(posedge clk); #2;
    in_valid = 1'b0;
    a_re = 8'($urandom);
    b_re = 8'($urandom);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    chk("wait_valid", out_valid, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_chk++;
      assert (q.size() > 0) n_pass++;
      else $error("FAIL spurious: observed unexpected output, required none");
      if (q.size() > 0) begin
        mon_exp = q.pop_front();
        mon_obs = {out_a_re, out_a_im, out_b_re, out_b_im, out_sat};
        n_out++;
        chk($sformatf("result#%0d", n_out), mon_obs, mon_exp);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, required finish");
    $fatal(1);
  end

  initial begin
    int   n;
    int   bad;
    int   base;
    op_t  o;
    op_t  sat_op;
    op_t  bp[5];
    exp_t e1;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", {out_a_re, out_a_im, out_b_re, out_b_im}, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_sat_count", sat_count, 0);
    @(posedge clk); #2;
    rst = 1'b0;

    // 0.5 + 0.25*(-1.0)
    issue(mk(64, 0, 32, 0, -128, 0, 0));
    idle();
    wait_valid(n);
    chk("t1_latency", n, 3);
    chk("t1_a_re", out_a_re, 32);
    chk("t1_a_im", out_a_im, 0);
    chk("t1_b_re", out_b_re, 96);
    chk("t1_sat", out_sat, 0);

    sat_op = mk(127, 0, 127, 0, -128, 0, 0);
    issue(sat_op);
    idle();
    wait_valid(n);
    chk("t2_a_re", out_a_re, 0);
    chk("t2_b_re", out_b_re, 127);
    chk("t2_sat", out_sat, 4'b0010);
    @(negedge clk);
    chk("t2_sat_count", sat_count, 1);

    issue(mk(127, 0, 127, 0, -128, 0, 1));
    idle();
    wait_valid(n);
    chk("t3_a_re", out_a_re, 0);
    chk("t3_b_re", out_b_re, 127);
    chk("t3_sat", out_sat, 0);
    @(negedge clk);
    chk("t3_sat_count", sat_count, 1);

    issue(mk(1, 0, 0, 0, 0, 0, 1));
    idle();
    wait_valid(n);
    chk("t4_round_up", out_a_re, 1);
    issue(mk(-1, 0, 0, 0, 0, 0, 1));
    idle();
    wait_valid(n);
    chk("t4_round_neg", out_a_re, 0);

    // -1.0 * -1.0 and mixed random traffic through the scoreboard
    issue(mk(0, 0, -128, 0, -128, 0, 0));
    issue(mk(-128, -128, -128, -128, -128, -128, 0));
    for (int i = 0; i < 20; i++) begin
      o = mk(int'($urandom_range(0, 255)) - 128,
             int'($urandom_range(0, 255)) - 128,
             int'($urandom_range(0, 255)) - 128,
             int'($urandom_range(0, 255)) - 128,
             int'($urandom_range(0, 255)) - 128,
             int'($urandom_range(0, 255)) - 128,
             1'($urandom_range(0, 1)));
      issue(o);
    end
    idle();
    drain();

    // Backpressure: five ops, output stalled for four cycles
    for (int i = 0; i < 5; i++)
      bp[i] = mk(10 * i, -5 * i, 20 + i, 7 - i, 90, -40 + i, 1'(i % 2));
    base = n_out;
    out_ready = 1'b0;
    issue(bp[0]);
    issue(bp[1]);
    issue(bp[2]);
    @(posedge clk); #2;
    drive(bp[3]);
    in_valid = 1'b1;
    e1 = model(bp[0]);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_handshake", {out_valid, in_ready}, 2'b10);
      chk("bp_frozen",
          {out_a_re, out_a_im, out_b_re, out_b_im, out_sat}, e1);
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", in_ready, 1);
    q.push_back(model(bp[3]));
    issue(bp[4]);
    idle();
    drain();
    chk("bp_count", n_out - base, 5);

    // Reset with operands in flight
    issue(mk(64, 0, 32, 0, -128, 0, 0));
    issue(mk(32, 32, 16, 16, 64, 64, 0));
    idle();
    @(posedge clk); #2;
    chk("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", {out_a_re, out_b_re, out_sat}, 0);
    chk("mid_rst_sat_count", sat_count, 0);
    q.delete();
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    chk("post_rst_quiet", bad, 0);
    issue(mk(64, 0, 32, 0, -128, 0, 0));
    idle();
    wait_valid(n);
    chk("post_rst_latency", n, 3);
    drain();

    // Counter saturation and clear priority
    for (int i = 0; i < 300; i++) issue(sat_op);
    idle();
    drain();
    @(negedge clk);
    chk("sat_count_sticky", sat_count, 255);
    issue(sat_op);
    idle();
    wait_valid(n);
    chk("clr_sat_flag", out_sat, 4'b0010);
    clear_sat = 1'b1;
    @(posedge clk); #2;
    clear_sat = 1'b0;
    @(negedge clk);
    chk("clear_priority", sat_count, 0);
    issue(sat_op);
    idle();
    wait_valid(n);
    @(negedge clk);
    chk("count_after_clear", sat_count, 1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
